// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared types and constants for the data memory arbiter:
//   - state_e    : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   - REQ_CORE / REQ_LOADER : requester identifiers
//   - MEM_LAT_MIN / MEM_LAT_MAX : legal memory read latency bounds
//   - CNT_W      : width of the read-latency wait counter
// -----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    // Three bits hold any legal latency without wrapping.
    localparam int CNT_W = 3;

    // Returns 1 when a latency value is inside the supported range.
    function automatic logic lat_in_range(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant logic with a last-grant pointer register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_i[1:0]   : request vector, bit 0 = core, bit 1 = loader
//   update_i     : pulse to record upd_id_i as the most recent grant
//   upd_id_i     : id of the requester whose access just completed
//   gnt_valid_o  : at least one request is present
//   gnt_id_o     : id of the winning requester (valid when gnt_valid_o)
// The pointer resets to "loader granted last" so the core wins the first tie.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import data_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       upd_id_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic last_q;
    logic last_d;
    logic gnt_id_s;

    // Grant selection: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        gnt_id_s = REQ_CORE;
        case (req_i)
            2'b01:   gnt_id_s = REQ_CORE;
            2'b10:   gnt_id_s = REQ_LOADER;
            2'b11:   gnt_id_s = ~last_q;
            default: gnt_id_s = REQ_CORE;
        endcase
    end

    // Pointer next-state: only moves on the completion pulse.
    always_comb begin
        if (update_i) begin
            last_d = upd_id_i;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_LOADER;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_valid_o = |req_i;
    assign gnt_id_o    = gnt_id_s;

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares a single-port data memory between the core (requester 0) and the
// loader (requester 1) with round-robin priority, sequences the memory
// strobes and returns read data with a one-cycle acknowledge.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   rN_req/we/addr/wdata      : requester N access request (held until ack)
//   rN_ack                    : one-cycle completion pulse
//   rN_rdata                  : last read result for requester N
//   mem_read, mem_write       : one-cycle memory strobes
//   mem_address/write_data    : registered access address / write data
//   mem_read_data             : memory read data, valid MEM_LAT cycles after strobe
//   core_stall                : core request pending (r0_req & ~r0_ack)
//   busy                      : sequencer not in IDLE
// MEM_LAT must lie in MEM_LAT_MIN..MEM_LAT_MAX (see package).
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              core_stall,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q,  state_d;
    logic              winner_q, winner_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              rd_q,     rd_d;
    logic              wr_q,     wr_d;
    logic              ack0_q,   ack0_d;
    logic              ack1_q,   ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q,   busy_d;

    logic              gnt_valid_s;
    logic              gnt_id_s;
    logic              arb_update_s;
    logic              sel_we_s;

    rr_arbiter2 u_rr_arbiter2 (
        .clk         (clk),
        .rst_n       (reset),
        .req_i       ({r1_req, r0_req}),
        .update_i    (arb_update_s),
        .upd_id_i    (winner_q),
        .gnt_valid_o (gnt_valid_s),
        .gnt_id_o    (gnt_id_s)
    );

    // Write-enable of the current arbitration winner.
    always_comb begin
        if (gnt_id_s == REQ_LOADER) begin
            sel_we_s = r1_we;
        end else begin
            sel_we_s = r0_we;
        end
    end

    // Sequencer next-state and datapath next-state logic.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        arb_update_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid_s) begin
                    // Capture the winning request; strobes are registered so
                    // they appear during ISSUE.
                    winner_d = gnt_id_s;
                    we_d     = sel_we_s;
                    if (gnt_id_s == REQ_LOADER) begin
                        addr_d  = r1_addr;
                        wdata_d = r1_wdata;
                    end else begin
                        addr_d  = r0_addr;
                        wdata_d = r0_wdata;
                    end
                    wr_d    = sel_we_s;
                    rd_d    = ~sel_we_s;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    // Write is done once the strobe is out; ack lands in RESP.
                    ack0_d  = (winner_q == REQ_CORE);
                    ack1_d  = (winner_q == REQ_LOADER);
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // Read data is valid this cycle; capture into the winner's register.
                    if (winner_q == REQ_LOADER) begin
                        rdata1_d = mem_read_data;
                    end else begin
                        rdata0_d = mem_read_data;
                    end
                    ack0_d  = (winner_q == REQ_CORE);
                    ack1_d  = (winner_q == REQ_LOADER);
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                // Completed access becomes the last grant, so the other side wins a tie.
                arb_update_s = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            winner_q <= REQ_CORE;
            we_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= {DATA_W{1'b0}};
            rdata1_q <= {DATA_W{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign r0_ack         = ack0_q;
    assign r1_ack         = ack1_q;
    assign r0_rdata       = rdata0_q;
    assign r1_rdata       = rdata1_q;
    assign busy           = busy_q;
    assign core_stall     = r0_req & ~ack0_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: four instances with MEM_LAT = 1..4 (index+1),
// each with its own memory model. Directed stimulus pushes expected acks into
// a scoreboard queue; a negedge monitor pops and compares on every ack.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          checks;
    int          failures;

    logic        r0_req   [4];
    logic        r0_we    [4];
    logic [15:0] r0_addr  [4];
    logic [15:0] r0_wdata [4];
    logic        r0_ack   [4];
    logic [15:0] r0_rdata [4];
    logic        r1_req   [4];
    logic        r1_we    [4];
    logic [15:0] r1_addr  [4];
    logic [15:0] r1_wdata [4];
    logic        r1_ack   [4];
    logic [15:0] r1_rdata [4];
    logic        mem_read [4];
    logic        mem_write[4];
    logic [15:0] mem_addr [4];
    logic [15:0] mem_wdata[4];
    logic [15:0] mem_rdata[4];
    logic        core_stall[4];
    logic        busy     [4];

    logic [15:0] mem      [4][256];
    int          lat_cnt  [4];

    typedef struct {
        int          inst;
        int          rid;
        bit          rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(g + 1)) dut (
            .clk           (clk),
            .reset         (rst_n),
            .r0_req        (r0_req[g]),
            .r0_we         (r0_we[g]),
            .r0_addr       (r0_addr[g]),
            .r0_wdata      (r0_wdata[g]),
            .r0_ack        (r0_ack[g]),
            .r0_rdata      (r0_rdata[g]),
            .r1_req        (r1_req[g]),
            .r1_we         (r1_we[g]),
            .r1_addr       (r1_addr[g]),
            .r1_wdata      (r1_wdata[g]),
            .r1_ack        (r1_ack[g]),
            .r1_rdata      (r1_rdata[g]),
            .mem_read      (mem_read[g]),
            .mem_write     (mem_write[g]),
            .mem_address   (mem_addr[g]),
            .mem_write_data(mem_wdata[g]),
            .mem_read_data (mem_rdata[g]),
            .core_stall    (core_stall[g]),
            .busy          (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: writes land on the strobe edge; read data is driven only
    // in the cycle MEM_LAT after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_write[i]) mem[i][mem_addr[i][7:0]] <= mem_wdata[i];
            if (mem_read[i]) lat_cnt[i] <= i + 1;
            else if (lat_cnt[i] != 0) lat_cnt[i] <= lat_cnt[i] - 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_rdata[i] = (lat_cnt[i] == 1) ? mem[i][mem_addr[i][7:0]] : 16'hDEAD;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 2; r++) begin
                if ((r == 0) ? r0_ack[i] : r1_ack[i]) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ack", 32'(i * 2 + r), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("ack_inst", 32'(i), 32'(e.inst));
                        chk("ack_rid", 32'(r), 32'(e.rid));
                        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.rd) chk("rdata", {16'h0000, (r == 0) ? r0_rdata[i] : r1_rdata[i]}, {16'h0000, e.data});
                    end
                end
            end
        end
    end

    task automatic issue(input int inst, input int rid, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rexp, input int ack_at);
        exp_t e;
        e.inst = inst; e.rid = rid; e.rd = ~we; e.data = rexp; e.cyc = ack_at;
        sb_q.push_back(e);
        if (rid == 0) begin
            r0_req[inst] = 1'b1; r0_we[inst] = we; r0_addr[inst] = addr; r0_wdata[inst] = wdata;
        end else begin
            r1_req[inst] = 1'b1; r1_we[inst] = we; r1_addr[inst] = addr; r1_wdata[inst] = wdata;
        end
    endtask

    // Waits (bounded) for the ack and drops req in the ack cycle.
    task automatic wait_ack(input int inst, input int rid);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if ((rid == 0) ? r0_ack[inst] : r1_ack[inst]) begin
                seen = 1'b1;
                if (rid == 0) r0_req[inst] = 1'b0;
                else r1_req[inst] = 1'b0;
            end
        end
        if (!seen) chk("ack_timeout", 32'(rid), 32'hFFFF_FFFF);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r0_req[i] = 1'b0; r1_req[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int c;
        int n;
        cyc = 0; checks = 0; failures = 0;
        for (int i = 0; i < 4; i++) begin
            r0_req[i] = 1'b0; r0_we[i] = 1'b0; r0_addr[i] = 16'h0000; r0_wdata[i] = 16'h0000;
            r1_req[i] = 1'b0; r1_we[i] = 1'b0; r1_addr[i] = 16'h0000; r1_wdata[i] = 16'h0000;
            lat_cnt[i] = 0;
        end
        mem[2][8'h20] = 16'h1234;
        mem[2][8'h30] = 16'h5A5A;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy[2]}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read[2]}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write[2]}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr[2]}, 32'd0);
        chk("rst_r0_rdata", {16'd0, r0_rdata[2]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: core write 0x0010 <= 0xBEEF on the MEM_LAT=3 instance.
        c = cyc;
        issue(2, 0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, c + 2);
        #1;
        chk("t1_stall_c0", {31'd0, core_stall[2]}, 32'd1);
        chk("t1_wr_c0", {31'd0, mem_write[2]}, 32'd0);
        @(negedge clk);
        chk("t1_wr_c1", {31'd0, mem_write[2]}, 32'd1);
        chk("t1_addr_c1", {16'd0, mem_addr[2]}, 32'h0010);
        chk("t1_wdata_c1", {16'd0, mem_wdata[2]}, 32'hBEEF);
        chk("t1_stall_c1", {31'd0, core_stall[2]}, 32'd1);
        chk("t1_busy_c1", {31'd0, busy[2]}, 32'd1);
        @(negedge clk);
        chk("t1_wr_c2", {31'd0, mem_write[2]}, 32'd0);
        chk("t1_stall_c2", {31'd0, core_stall[2]}, 32'd0);
        chk("t1_ack_c2", {31'd0, r0_ack[2]}, 32'd1);
        r0_req[2] = 1'b0;
        @(negedge clk);
        chk("t1_busy_c3", {31'd0, busy[2]}, 32'd0);

        // T2: loader read 0x0020 with MEM_LAT=3 returns 0x1234, ack at cycle 5.
        c = cyc;
        issue(2, 1, 1'b0, 16'h0020, 16'h0000, 16'h1234, c + 5);
        @(negedge clk);
        chk("t2_rd_c1", {31'd0, mem_read[2]}, 32'd1);
        chk("t2_addr_c1", {16'd0, mem_addr[2]}, 32'h0020);
        wait_ack(2, 1);
        @(negedge clk);
        chk("t2_r1_rdata_hold", {16'd0, r1_rdata[2]}, 32'h1234);
        chk("t2_r0_rdata", {16'd0, r0_rdata[2]}, 32'h0000);

        // T3: both requesters continuously from reset; grants alternate r0, r1, ...
        do_reset();
        c = cyc;
        for (int k = 0; k < 8; k++) begin
            issue(2, k % 2, 1'b1, 16'(16'h0100 + k), 16'(16'hC000 + k), 16'h0000, c + 2 + 3 * k);
            sb_q.pop_back();
        end
        r0_req[2] = 1'b1; r0_we[2] = 1'b1; r0_addr[2] = 16'h0100; r0_wdata[2] = 16'hC000;
        r1_req[2] = 1'b1; r1_we[2] = 1'b1; r1_addr[2] = 16'h0101; r1_wdata[2] = 16'hC001;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.inst = 2; e.rid = k % 2; e.rd = 1'b0; e.data = 16'h0000; e.cyc = c + 2 + 3 * k;
            sb_q.push_back(e);
        end
        n = 0;
        for (int t = 0; t < 60 && n < 8; t++) begin
            @(negedge clk);
            if (r0_ack[2] || r1_ack[2]) n++;
        end
        r0_req[2] = 1'b0; r1_req[2] = 1'b0;
        chk("t3_ack_count", 32'(n), 32'd8);

        // T4: loader drops req during WAIT; access still acks, then core wins.
        @(negedge clk);
        c = cyc;
        issue(2, 1, 1'b0, 16'h0030, 16'h0000, 16'h5A5A, c + 5);
        repeat (2) @(negedge clk);
        r1_req[2] = 1'b0;
        issue(2, 0, 1'b1, 16'h0050, 16'h7777, 16'h0000, c + 8);
        repeat (5) @(negedge clk);
        chk("t4_stall_pending", {31'd0, core_stall[2]}, 32'd1);
        wait_ack(2, 0);

        // T5: reset during WAIT of a core read aborts it with no ack.
        @(negedge clk);
        c = cyc;
        r0_req[2] = 1'b1; r0_we[2] = 1'b0; r0_addr[2] = 16'h0020;
        @(negedge clk);
        chk("t5_rd_c1", {31'd0, mem_read[2]}, 32'd1);
        @(negedge clk);
        chk("t5_busy_wait", {31'd0, busy[2]}, 32'd1);
        rst_n = 1'b0;
        r0_req[2] = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, busy[2]}, 32'd0);
        chk("t5_rst_addr", {16'd0, mem_addr[2]}, 32'd0);
        chk("t5_rst_r1_rdata", {16'd0, r1_rdata[2]}, 32'd0);
        chk("t5_rst_ack", {31'd0, r0_ack[2]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("t5_no_strobe", {30'd0, mem_read[2], mem_write[2]}, 32'd0);
        end
        c = cyc;
        issue(2, 0, 1'b0, 16'h0020, 16'h0000, 16'h1234, c + 5);
        wait_ack(2, 0);

        // T6: read-after-write on every latency instance.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue(i, 0, 1'b1, 16'h0040, 16'(16'hA000 + i), 16'h0000, cyc + 2);
            wait_ack(i, 0);
            @(negedge clk);
            issue(i, 0, 1'b0, 16'h0040, 16'h0000, 16'(16'hA000 + i), cyc + 2 + (i + 1));
            wait_ack(i, 0);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
